seg_owner_arbiter: RTL and testbench

Time-shares the 8-digit seven-segment display between three sources: the always-present mode/status pattern, transient readout messages, and high-priority blinking alerts. It sits between the status mapper and `hex_display`, and drives that scanner's 32-bit nibble word and 8-bit digit-enable. It enforces message hold times and the alert blink cadence, and tells each requester when its content was taken or pre-empted.

---
 rtl/seg_owner_arbiter_pkg.sv | 20 ++
 rtl/seg_blink_timer.sv | 68 ++++++
 rtl/seg_owner_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_seg_owner_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_owner_arbiter_pkg.sv
// Shared owner codes, FSM state type and counter sizing helper for the
// seven-segment display owner arbiter.
package seg_owner_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MSG   = 2'd1,
    ST_ALERT = 2'd2
  } state_e;

  localparam logic [1:0] OWN_BASE  = 2'd0;
  localparam logic [1:0] OWN_MSG   = 2'd1;
  localparam logic [1:0] OWN_ALERT = 2'd2;

  // A count of one still needs a one-bit counter.
  function automatic int cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// Alert blink cadence: on/off phases of BLINK_CYCLES each, ALERT_FLASHES pairs.
// phase_on is the phase to show after the coming edge; done flags the final cycle.
module seg_blink_timer
  import seg_owner_arbiter_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES  = 12_500_000,
  parameter int unsigned ALERT_FLASHES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic phase_on,
  output logic done
);

  localparam int CNT_W  = cnt_width(BLINK_CYCLES);
  localparam int PAIR_W = cnt_width(ALERT_FLASHES);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              off_q,  off_d;
  logic              phase_end;
  logic              last_pair;

  // Phase/pair counter next-state; start always rewinds to the first on-phase.
  always_comb begin
    phase_end = (cnt_q == CNT_W'(BLINK_CYCLES - 32'd1));
    last_pair = (pair_q == PAIR_W'(ALERT_FLASHES - 32'd1));
    cnt_d     = cnt_q;
    off_d     = off_q;
    pair_d    = pair_q;
    if (start) begin
      cnt_d  = '0;
      off_d  = 1'b0;
      pair_d = '0;
    end else if (phase_end) begin
      cnt_d = '0;
      off_d = ~off_q;
      if (off_q) begin
        pair_d = last_pair ? '0 : pair_q + PAIR_W'(1);
      end else begin
        pair_d = pair_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs look only at registered state so the parent can use them combinationally.
  always_comb begin
    phase_on = phase_end ? off_q : ~off_q;
    done     = phase_end & off_q & last_pair;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      off_q  <= 1'b0;
      pair_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      off_q  <= off_d;
      pair_q <= pair_d;
    end
  end

endmodule

// File: rtl/seg_owner_arbiter.sv
// Time-shares the 8-digit display between base status, held messages and
// blinking alerts (alert > message > base). All outputs are registered.
module seg_owner_arbiter
  import seg_owner_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned BLINK_CYCLES  = 12_500_000,
  parameter int unsigned ALERT_FLASHES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] base_data,
  input  logic [7:0]  base_en,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  input  logic [7:0]  msg_en,
  output logic        msg_ack,
  output logic        msg_abort,
  input  logic        alert_req,
  input  logic [31:0] alert_data,
  input  logic [7:0]  alert_en,
  output logic        alert_ack,
  output logic [31:0] disp_data,
  output logic [7:0]  disp_en,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       msg_data_q, msg_data_d;
  logic [7:0]        msg_en_q, msg_en_d;
  logic [31:0]       alert_data_q, alert_data_d;
  logic [7:0]        alert_en_q, alert_en_d;
  logic [31:0]       disp_data_q, disp_data_d;
  logic [7:0]        disp_en_q, disp_en_d;
  logic [1:0]        owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              msg_ack_q, msg_ack_d;
  logic              msg_abort_q, msg_abort_d;
  logic              alert_ack_q, alert_ack_d;
  logic              blink_start;
  logic              blink_on;
  logic              blink_done;

  seg_blink_timer #(
    .BLINK_CYCLES  (BLINK_CYCLES),
    .ALERT_FLASHES (ALERT_FLASHES)
  ) u_blink (
    .clk      (clk),
    .rst      (rst),
    .start    (blink_start),
    .phase_on (blink_on),
    .done     (blink_done)
  );

  // Next state, latches and display values; the display word is computed one
  // edge ahead so the new owner's content appears in the same cycle as its ack.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    msg_data_d   = msg_data_q;
    msg_en_d     = msg_en_q;
    alert_data_d = alert_data_q;
    alert_en_d   = alert_en_q;
    disp_data_d  = disp_data_q;
    disp_en_d    = disp_en_q;
    owner_d      = owner_q;
    msg_ack_d    = 1'b0;
    msg_abort_d  = 1'b0;
    alert_ack_d  = 1'b0;
    blink_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (alert_req) begin
          state_d      = ST_ALERT;
          alert_ack_d  = 1'b1;
          alert_data_d = alert_data;
          alert_en_d   = alert_en;
          disp_data_d  = alert_data;
          disp_en_d    = alert_en;
          owner_d      = OWN_ALERT;
          blink_start  = 1'b1;
        end else if (msg_req) begin
          state_d     = ST_MSG;
          msg_ack_d   = 1'b1;
          msg_data_d  = msg_data;
          msg_en_d    = msg_en;
          disp_data_d = msg_data;
          disp_en_d   = msg_en;
          owner_d     = OWN_MSG;
          hold_d      = '0;
        end else begin
          disp_data_d = base_data;
          disp_en_d   = base_en;
          owner_d     = OWN_BASE;
        end
      end

      ST_MSG: begin
        if (alert_req) begin
          state_d      = ST_ALERT;
          alert_ack_d  = 1'b1;
          msg_abort_d  = 1'b1;
          alert_data_d = alert_data;
          alert_en_d   = alert_en;
          disp_data_d  = alert_data;
          disp_en_d    = alert_en;
          owner_d      = OWN_ALERT;
          blink_start  = 1'b1;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 32'd1)) begin
          state_d     = ST_IDLE;
          hold_d      = '0;
          disp_data_d = base_data;
          disp_en_d   = base_en;
          owner_d     = OWN_BASE;
        end else begin
          hold_d      = hold_q + HOLD_W'(1);
          disp_data_d = msg_data_q;
          disp_en_d   = msg_en_q;
          owner_d     = OWN_MSG;
        end
      end

      ST_ALERT: begin
        if (blink_done) begin
          state_d     = ST_IDLE;
          disp_data_d = base_data;
          disp_en_d   = base_en;
          owner_d     = OWN_BASE;
        end else begin
          disp_data_d = alert_data_q;
          disp_en_d   = blink_on ? alert_en_q : 8'h00;
          owner_d     = OWN_ALERT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        hold_d      = '0;
        disp_data_d = base_data;
        disp_en_d   = base_en;
        owner_d     = OWN_BASE;
      end
    endcase

    busy_d = (owner_d != OWN_BASE);
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      msg_data_q   <= 32'h0;
      msg_en_q     <= 8'h00;
      alert_data_q <= 32'h0;
      alert_en_q   <= 8'h00;
      disp_data_q  <= 32'h0;
      disp_en_q    <= 8'h00;
      owner_q      <= OWN_BASE;
      busy_q       <= 1'b0;
      msg_ack_q    <= 1'b0;
      msg_abort_q  <= 1'b0;
      alert_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      msg_data_q   <= msg_data_d;
      msg_en_q     <= msg_en_d;
      alert_data_q <= alert_data_d;
      alert_en_q   <= alert_en_d;
      disp_data_q  <= disp_data_d;
      disp_en_q    <= disp_en_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      msg_ack_q    <= msg_ack_d;
      msg_abort_q  <= msg_abort_d;
      alert_ack_q  <= alert_ack_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_en   = disp_en_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign msg_ack   = msg_ack_q;
  assign msg_abort = msg_abort_q;
  assign alert_ack = alert_ack_q;

endmodule

// File: tb/tb_seg_owner_arbiter.sv
// Directed bench for seg_owner_arbiter with HOLD_CYCLES=10, BLINK_CYCLES=4,
// ALERT_FLASHES=2; inputs driven and outputs sampled on the falling edge.
module tb_seg_owner_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base_data;
  logic [7:0]  base_en;
  logic        msg_req;
  logic [31:0] msg_data;
  logic [7:0]  msg_en;
  logic        msg_ack;
  logic        msg_abort;
  logic        alert_req;
  logic [31:0] alert_data;
  logic [7:0]  alert_en;
  logic        alert_ack;
  logic [31:0] disp_data;
  logic [7:0]  disp_en;
  logic [1:0]  owner;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  seg_owner_arbiter #(
    .HOLD_CYCLES   (10),
    .BLINK_CYCLES  (4),
    .ALERT_FLASHES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .base_data  (base_data),
    .base_en    (base_en),
    .msg_req    (msg_req),
    .msg_data   (msg_data),
    .msg_en     (msg_en),
    .msg_ack    (msg_ack),
    .msg_abort  (msg_abort),
    .alert_req  (alert_req),
    .alert_data (alert_data),
    .alert_en   (alert_en),
    .alert_ack  (alert_ack),
    .disp_data  (disp_data),
    .disp_en    (disp_en),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Expected blink enable for alert cycle c (1-based): on, on, on, on, off x4, ...
  function automatic logic [7:0] blink_exp(input int c, input logic [7:0] en);
    return (((c - 1) / 4) % 2 == 0) ? en : 8'h00;
  endfunction

  initial begin
    rst = 1'b1;
    base_data = 32'h0; base_en = 8'h00;
    msg_req = 1'b0; msg_data = 32'h0; msg_en = 8'h00;
    alert_req = 1'b0; alert_data = 32'h0; alert_en = 8'h00;
    step(2);

    // Reset state
    check("rst_disp_en", {24'h0, disp_en}, 32'h0);
    check("rst_disp_data", disp_data, 32'h0);
    check("rst_owner", {30'h0, owner}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_acks", {29'h0, msg_ack, msg_abort, alert_ack}, 32'h0);

    // Base path: one cycle latency
    rst = 1'b0;
    base_data = 32'hAAA0_0000; base_en = 8'hE0;
    step(1);
    check("base_data", disp_data, 32'hAAA0_0000);
    check("base_en", {24'h0, disp_en}, 32'h0000_00E0);

    // Message held exactly 10 cycles
    msg_req = 1'b1; msg_data = 32'h0000_1234; msg_en = 8'h0F;
    step(1);
    check("msg_ack", {31'h0, msg_ack}, 32'h1);
    check("msg_owner", {30'h0, owner}, 32'h1);
    check("msg_busy", {31'h0, busy}, 32'h1);
    check("msg_data_c1", disp_data, 32'h0000_1234);
    check("msg_en_c1", {24'h0, disp_en}, 32'h0000_000F);
    msg_req = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step(1);
      check("msg_hold_data", disp_data, 32'h0000_1234);
      check("msg_hold_owner", {30'h0, owner}, 32'h1);
      check("msg_ack_pulse", {31'h0, msg_ack}, 32'h0);
    end
    step(1);
    check("msg_end_owner", {30'h0, owner}, 32'h0);
    check("msg_end_data", disp_data, 32'hAAA0_0000);
    check("msg_end_busy", {31'h0, busy}, 32'h0);

    // Alert blink FF x4, 00 x4, FF x4, 00 x4
    alert_req = 1'b1; alert_data = 32'hDEAD_BEEF; alert_en = 8'hFF;
    step(1);
    check("alert_ack", {31'h0, alert_ack}, 32'h1);
    check("alert_owner", {30'h0, owner}, 32'h2);
    check("alert_data", disp_data, 32'hDEAD_BEEF);
    check("alert_en_c1", {24'h0, disp_en}, 32'h0000_00FF);
    alert_req = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step(1);
      check("alert_blink_en", {24'h0, disp_en}, {24'h0, blink_exp(c, 8'hFF)});
      check("alert_blink_owner", {30'h0, owner}, 32'h2);
    end
    step(1);
    check("alert_end_owner", {30'h0, owner}, 32'h0);
    check("alert_end_en", {24'h0, disp_en}, 32'h0000_00E0);

    // Pre-emption on cycle 5 of a message
    msg_req = 1'b1; msg_data = 32'h0000_5678; msg_en = 8'h0F;
    step(1);
    check("pre_msg_ack", {31'h0, msg_ack}, 32'h1);
    msg_req = 1'b0;
    step(4);
    check("pre_msg_c5", disp_data, 32'h0000_5678);
    alert_req = 1'b1; alert_data = 32'h0000_0BAD; alert_en = 8'h3C;
    step(1);
    check("pre_alert_ack", {31'h0, alert_ack}, 32'h1);
    check("pre_msg_abort", {31'h0, msg_abort}, 32'h1);
    check("pre_owner", {30'h0, owner}, 32'h2);
    check("pre_data", disp_data, 32'h0000_0BAD);
    alert_req = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step(1);
      check("pre_blink_data", disp_data, 32'h0000_0BAD);
      check("pre_blink_en", {24'h0, disp_en}, {24'h0, blink_exp(c, 8'h3C)});
      check("pre_abort_pulse", {31'h0, msg_abort}, 32'h0);
    end
    step(1);
    check("pre_end_owner", {30'h0, owner}, 32'h0);
    check("pre_end_data", disp_data, 32'hAAA0_0000);
    step(1);
    check("pre_no_resume", {30'h0, owner}, 32'h0);

    // Simultaneous requests: alert first, message after alert ends
    msg_req = 1'b1; msg_data = 32'h0000_5555; msg_en = 8'hFF;
    alert_req = 1'b1; alert_data = 32'h0000_7777; alert_en = 8'hFF;
    step(1);
    check("sim_alert_ack", {31'h0, alert_ack}, 32'h1);
    check("sim_no_msg_ack", {31'h0, msg_ack}, 32'h0);
    check("sim_owner", {30'h0, owner}, 32'h2);
    alert_req = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step(1);
      check("sim_msg_wait", {31'h0, msg_ack}, 32'h0);
    end
    step(1);
    check("sim_idle_owner", {30'h0, owner}, 32'h0);
    check("sim_idle_no_ack", {31'h0, msg_ack}, 32'h0);
    step(1);
    check("sim_msg_ack", {31'h0, msg_ack}, 32'h1);
    check("sim_msg_owner", {30'h0, owner}, 32'h1);
    check("sim_msg_data", disp_data, 32'h0000_5555);
    msg_req = 1'b0;
    step(10);
    check("sim_msg_end", {30'h0, owner}, 32'h0);

    // Reset during an off-phase; held alert re-acked after release
    alert_req = 1'b1; alert_data = 32'h0000_1111; alert_en = 8'h0F;
    step(1);
    check("ra_ack", {31'h0, alert_ack}, 32'h1);
    step(5);
    check("ra_off_phase", {24'h0, disp_en}, 32'h0);
    check("ra_owner", {30'h0, owner}, 32'h2);
    rst = 1'b1;
    step(1);
    check("ra_rst_owner", {30'h0, owner}, 32'h0);
    check("ra_rst_data", disp_data, 32'h0);
    check("ra_rst_en", {24'h0, disp_en}, 32'h0);
    check("ra_rst_busy", {31'h0, busy}, 32'h0);
    check("ra_rst_ack", {31'h0, alert_ack}, 32'h0);
    step(1);
    check("ra_rst_ack_hold", {31'h0, alert_ack}, 32'h0);
    rst = 1'b0;
    step(1);
    check("ra_reack", {31'h0, alert_ack}, 32'h1);
    check("ra_reack_owner", {30'h0, owner}, 32'h2);
    check("ra_reack_en", {24'h0, disp_en}, 32'h0000_000F);
    alert_req = 1'b0;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
